// File: rtl/cpu_datapath_if.sv
// Memory bus between the CPU datapath (master) and the memory system (slave).
// A transfer is requested while mem_enable is high and completes on the last T-cycle when mem_ready is high.
interface cpu_datapath_if;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_enable, mem_write, mem_data_out,
        input  mem_data_in, mem_ready
    );

    modport slave (
        input  mem_addr, mem_enable, mem_write, mem_data_out,
        output mem_data_in, mem_ready
    );
endinterface

// File: rtl/cpu_datapath.sv
// 8-bit CPU datapath: register file, ALU, PC/IR, and a T-cycle sequencer that commits once per M-cycle.
// Define CPU_DATAPATH_WAIT_STATE_EN to let mem_ready stretch the last T-cycle; otherwise mem_ready is ignored.
module cpu_datapath #(
    parameter int          T_PER_M  = 4,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ctl_pc_op,
    input  logic         ctl_ir_load,
    input  logic [3:0]   ctl_rd1_sel,
    input  logic [3:0]   ctl_rd2_sel,
    input  logic [3:0]   ctl_wr_sel,
    input  logic [2:0]   ctl_reg_op,
    input  logic [2:0]   ctl_alu_op,
    input  logic         ctl_flag_we,
    input  logic         ctl_mem_en,
    input  logic         ctl_mem_wr,
    input  logic [1:0]   ctl_addr_sel,
    cpu_datapath_if.master mem,
    output logic [3:0]   t_cycle,
    output logic         m_end,
    output logic [7:0]   ir,
    output logic [3:0]   flags
);
    localparam logic [3:0] T_LAST = 4'(T_PER_M - 1);
    localparam int         F_IDX  = 6;

    logic [3:0]  t_q, t_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q;
    logic [7:0]  regs_q [12];
    logic [7:0]  regs_d [12];
    logic        last_t, stall;
    logic [7:0]  rd1, rd2, alu_res;
    logic        alu_z, alu_n, alu_h, alu_c;
    logic [8:0]  wide;
    logic [4:0]  half;
    logic [3:0]  wr_lo;
    logic        pair_ok;
    logic [15:0] pair16;

    assign last_t = (t_q == T_LAST);

`ifdef CPU_DATAPATH_WAIT_STATE_EN
    assign stall = last_t && ctl_mem_en && !mem.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem.mem_ready;
    assign stall = 1'b0;
`endif

    // T-cycle sequencer: state register, next-state, outputs
    always_ff @(posedge clk) begin
        if (reset) t_q <= 4'd0;
        else       t_q <= t_d;
    end

    always_comb begin
        t_d = t_q;
        if (!stall) t_d = last_t ? 4'd0 : t_q + 4'd1;
    end

    always_comb begin
        t_cycle = t_q;
        m_end   = last_t && !stall && !reset;
    end

    assign rd1 = (ctl_rd1_sel < 4'd12) ? regs_q[ctl_rd1_sel] : 8'h00;
    assign rd2 = (ctl_rd2_sel < 4'd12) ? regs_q[ctl_rd2_sel] : 8'h00;

    // Flags default to the stored F so COPY and the C of INC/DEC fall through unchanged
    always_comb begin
        alu_res = rd1;
        {alu_z, alu_n, alu_h, alu_c} = regs_q[F_IDX][7:4];
        wide = 9'd0;
        half = 5'd0;
        case (ctl_alu_op)
            3'd1: begin alu_res = rd1 + 8'd1; alu_n = 1'b0; alu_h = (rd1[3:0] == 4'hF); end
            3'd2: begin alu_res = rd1 - 8'd1; alu_n = 1'b1; alu_h = (rd1[3:0] == 4'h0); end
            3'd3: begin
                wide = {1'b0, rd1} + {1'b0, rd2};
                half = {1'b0, rd1[3:0]} + {1'b0, rd2[3:0]};
                alu_res = wide[7:0]; alu_n = 1'b0; alu_h = half[4]; alu_c = wide[8];
            end
            3'd4: begin
                wide = {1'b0, rd1} - {1'b0, rd2};
                half = {1'b0, rd1[3:0]} - {1'b0, rd2[3:0]};
                alu_res = wide[7:0]; alu_n = 1'b1; alu_h = half[4]; alu_c = wide[8];
            end
            3'd5: begin alu_res = rd1 & rd2; alu_n = 1'b0; alu_h = 1'b1; alu_c = 1'b0; end
            3'd6: begin alu_res = rd1 | rd2; alu_n = 1'b0; alu_h = 1'b0; alu_c = 1'b0; end
            3'd7: begin alu_res = rd1 ^ rd2; alu_n = 1'b0; alu_h = 1'b0; alu_c = 1'b0; end
            default: ;
        endcase
        if (ctl_alu_op != 3'd0) alu_z = (alu_res == 8'h00);
    end

    assign wr_lo   = ctl_wr_sel | 4'd1;
    assign pair_ok = !ctl_wr_sel[0] && (ctl_wr_sel < 4'd12);

    always_comb begin
        regs_d = regs_q;
        pair16 = 16'h0000;
        if (pair_ok) pair16 = {regs_q[ctl_wr_sel], regs_q[wr_lo]};
        case (ctl_reg_op)
            3'd1: if (ctl_wr_sel < 4'd12) regs_d[ctl_wr_sel] = alu_res;
            3'd2: if (ctl_wr_sel < 4'd12) regs_d[ctl_wr_sel] = mem.mem_data_in;
            3'd3: if (pair_ok) {regs_d[ctl_wr_sel], regs_d[wr_lo]} = pair16 + 16'd1;
            3'd4: if (pair_ok) {regs_d[ctl_wr_sel], regs_d[wr_lo]} = pair16 - 16'd1;
            default: ;
        endcase
        // F keeps a zero low nibble; a flag write overrides any register write to F
        regs_d[F_IDX][3:0] = 4'h0;
        if (ctl_flag_we) regs_d[F_IDX] = {alu_z, alu_n, alu_h, alu_c, 4'h0};
    end

    always_comb begin
        case (ctl_pc_op)
            2'd1:    pc_d = pc_q + 16'd1;
            2'd2:    pc_d = {regs_q[10], regs_q[11]};
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
            ir_q <= 8'h00;
            for (int i = 0; i < 12; i++) regs_q[i] <= 8'h00;
        end else if (m_end) begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            if (ctl_ir_load) ir_q <= mem.mem_data_in;
        end
    end

    always_comb begin
        mem.mem_enable   = ctl_mem_en;
        mem.mem_write    = ctl_mem_en & ctl_mem_wr;
        mem.mem_data_out = alu_res;
        case (ctl_addr_sel)
            2'd0:    mem.mem_addr = pc_q;
            2'd1:    mem.mem_addr = {regs_q[4], regs_q[5]};
            2'd2:    mem.mem_addr = {rd1, rd2};
            default: mem.mem_addr = {8'hFF, rd2};
        endcase
    end

    assign ir    = ir_q;
    assign flags = regs_q[F_IDX][7:4];
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: a T_PER_M=4 instance for the main function and a T_PER_M=2 instance for reset-in-stall.
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic reset, reset2;
  logic [1:0] ctl_pc_op, ctl_addr_sel;
  logic ctl_ir_load, ctl_flag_we, ctl_mem_en, ctl_mem_wr;
  logic [3:0] ctl_rd1_sel, ctl_rd2_sel, ctl_wr_sel;
  logic [2:0] ctl_reg_op, ctl_alu_op;
  logic [3:0] t_cycle, flags, t_cycle2, flags2;
  logic m_end, m_end2;
  logic [7:0] ir, ir2;
  int n_total = 0;
  int n_pass = 0;

  cpu_datapath_if bus();
  cpu_datapath_if bus2();

  cpu_datapath #(.T_PER_M(4), .PC_RESET(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .ctl_pc_op(ctl_pc_op), .ctl_ir_load(ctl_ir_load),
    .ctl_rd1_sel(ctl_rd1_sel), .ctl_rd2_sel(ctl_rd2_sel), .ctl_wr_sel(ctl_wr_sel),
    .ctl_reg_op(ctl_reg_op), .ctl_alu_op(ctl_alu_op), .ctl_flag_we(ctl_flag_we),
    .ctl_mem_en(ctl_mem_en), .ctl_mem_wr(ctl_mem_wr), .ctl_addr_sel(ctl_addr_sel),
    .mem(bus), .t_cycle(t_cycle), .m_end(m_end), .ir(ir), .flags(flags));

  cpu_datapath #(.T_PER_M(2), .PC_RESET(16'h0100)) u_dut2 (
    .clk(clk), .reset(reset2), .ctl_pc_op(ctl_pc_op), .ctl_ir_load(ctl_ir_load),
    .ctl_rd1_sel(ctl_rd1_sel), .ctl_rd2_sel(ctl_rd2_sel), .ctl_wr_sel(ctl_wr_sel),
    .ctl_reg_op(ctl_reg_op), .ctl_alu_op(ctl_alu_op), .ctl_flag_we(ctl_flag_we),
    .ctl_mem_en(ctl_mem_en), .ctl_mem_wr(ctl_mem_wr), .ctl_addr_sel(ctl_addr_sel),
    .mem(bus2), .t_cycle(t_cycle2), .m_end(m_end2), .ir(ir2), .flags(flags2));

  always #5 clk = ~clk;

  task automatic idle();
    ctl_pc_op = 2'd0; ctl_ir_load = 1'b0; ctl_rd1_sel = 4'd0; ctl_rd2_sel = 4'd0;
    ctl_wr_sel = 4'd0; ctl_reg_op = 3'd0; ctl_alu_op = 3'd0; ctl_flag_we = 1'b0;
    ctl_mem_en = 1'b0; ctl_mem_wr = 1'b0; ctl_addr_sel = 2'd0;
    bus.mem_data_in = 8'h00; bus.mem_ready = 1'b1;
    bus2.mem_data_in = 8'h00; bus2.mem_ready = 1'b1;
  endtask

  task automatic mcycle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input logic [3:0] idx, input logic [7:0] v);
    idle();
    ctl_reg_op = 3'd2; ctl_wr_sel = idx; bus.mem_data_in = v;
    mcycle();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1; idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (m_end !== 1'b1) $display("FAIL pre_reset_m_end: got %b want 1", m_end); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (m_end !== 1'b0) $display("FAIL m_end_in_reset: got %b want 0", m_end); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    n_total++; if (t_cycle !== 4'd0) $display("FAIL reset_t: got %0d want 0", t_cycle); else n_pass++;
    n_total++; if (bus.mem_addr !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", bus.mem_addr); else n_pass++;
    n_total++; if (ir !== 8'h00) $display("FAIL reset_ir: got %h want 00", ir); else n_pass++;
    n_total++; if (flags !== 4'h0) $display("FAIL reset_flags: got %h want 0", flags); else n_pass++;
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd0; ctl_rd2_sel = 4'd1;
    #1;
    n_total++; if (bus.mem_addr !== 16'h0000) $display("FAIL reset_bc: got %h want 0000", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_pc_inc();
    ctl_pc_op = 2'd1;
    for (int m = 0; m < 3; m++) begin
      for (int t = 0; t < 4; t++) begin
        logic exp_m;
        exp_m = (t == 3);
        n_total++; if (t_cycle !== 4'(t)) $display("FAIL pc_inc_t: got %0d want %0d", t_cycle, t); else n_pass++;
        n_total++; if (m_end !== exp_m) $display("FAIL pc_inc_m_end t=%0d: got %b want %b", t, m_end, exp_m); else n_pass++;
        n_total++; if (bus.mem_addr !== 16'(m)) $display("FAIL pc_inc_pc: got %h want %h", bus.mem_addr, 16'(m)); else n_pass++;
        @(posedge clk);
        #1;
      end
    end
    n_total++; if (bus.mem_addr !== 16'h0003) $display("FAIL pc_inc_final: got %h want 0003", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_add();
    load_reg(4'd7, 8'h0F); load_reg(4'd0, 8'h01);
    ctl_alu_op = 3'd3; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd0; ctl_reg_op = 3'd1; ctl_wr_sel = 4'd7; ctl_flag_we = 1'b1;
    #1;
    n_total++; if (bus.mem_data_out !== 8'h10) $display("FAIL add_res: got %h want 10", bus.mem_data_out); else n_pass++;
    mcycle(); idle();
    n_total++; if (flags !== 4'h2) $display("FAIL add_flags: got %h want 2", flags); else n_pass++;
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd6;
    #1;
    n_total++; if (bus.mem_addr !== 16'h1020) $display("FAIL add_a_f: got %h want 1020", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_sub_inc();
    load_reg(4'd7, 8'h00);
    ctl_alu_op = 3'd4; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd0; ctl_reg_op = 3'd1; ctl_wr_sel = 4'd7; ctl_flag_we = 1'b1;
    #1;
    n_total++; if (bus.mem_data_out !== 8'hFF) $display("FAIL sub_res: got %h want ff", bus.mem_data_out); else n_pass++;
    mcycle(); idle();
    n_total++; if (flags !== 4'h7) $display("FAIL sub_flags: got %h want 7", flags); else n_pass++;
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd6;
    #1;
    n_total++; if (bus.mem_addr !== 16'hFF70) $display("FAIL sub_a_f: got %h want ff70", bus.mem_addr); else n_pass++;
    idle();
    ctl_alu_op = 3'd1; ctl_rd1_sel = 4'd7; ctl_reg_op = 3'd1; ctl_wr_sel = 4'd7; ctl_flag_we = 1'b1;
    #1;
    n_total++; if (bus.mem_data_out !== 8'h00) $display("FAIL inc_res: got %h want 00", bus.mem_data_out); else n_pass++;
    mcycle(); idle();
    n_total++; if (flags !== 4'hB) $display("FAIL inc_flags: got %h want b", flags); else n_pass++;
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd6;
    #1;
    n_total++; if (bus.mem_addr !== 16'h00B0) $display("FAIL inc_a_f: got %h want 00b0", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_flags_logic();
    // A=00, B=01: AND with flag write beats a memory write of FF into F
    ctl_reg_op = 3'd2; ctl_wr_sel = 4'd6; bus.mem_data_in = 8'hFF;
    ctl_alu_op = 3'd5; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd0; ctl_flag_we = 1'b1;
    mcycle(); idle();
    n_total++; if (flags !== 4'hA) $display("FAIL and_prio_flags: got %h want a", flags); else n_pass++;
    load_reg(4'd6, 8'hFF);
    n_total++; if (flags !== 4'hF) $display("FAIL f_write_flags: got %h want f", flags); else n_pass++;
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd6; ctl_rd2_sel = 4'd6;
    #1;
    n_total++; if (bus.mem_addr !== 16'hF0F0) $display("FAIL f_low_nibble: got %h want f0f0", bus.mem_addr); else n_pass++;
    idle();
    ctl_alu_op = 3'd0; ctl_rd1_sel = 4'd0; ctl_flag_we = 1'b1;
    #1;
    n_total++; if (bus.mem_data_out !== 8'h01) $display("FAIL copy_res: got %h want 01", bus.mem_data_out); else n_pass++;
    mcycle(); idle();
    n_total++; if (flags !== 4'hF) $display("FAIL copy_flags: got %h want f", flags); else n_pass++;
    ctl_alu_op = 3'd7; ctl_rd1_sel = 4'd0; ctl_rd2_sel = 4'd0; ctl_flag_we = 1'b1;
    mcycle(); idle();
    n_total++; if (flags !== 4'h8) $display("FAIL xor_flags: got %h want 8", flags); else n_pass++;
    ctl_alu_op = 3'd6; ctl_rd1_sel = 4'd7; ctl_rd2_sel = 4'd0; ctl_flag_we = 1'b1;
    #1;
    n_total++; if (bus.mem_data_out !== 8'h01) $display("FAIL or_res: got %h want 01", bus.mem_data_out); else n_pass++;
    mcycle(); idle();
    n_total++; if (flags !== 4'h0) $display("FAIL or_flags: got %h want 0", flags); else n_pass++;
  endtask

  task automatic test_inc16();
    load_reg(4'd4, 8'hFF); load_reg(4'd5, 8'hFF);
    ctl_reg_op = 3'd3; ctl_wr_sel = 4'd4;
    mcycle(); idle();
    ctl_addr_sel = 2'd1;
    #1;
    n_total++; if (bus.mem_addr !== 16'h0000) $display("FAIL inc16_wrap: got %h want 0000", bus.mem_addr); else n_pass++;
    ctl_reg_op = 3'd4; ctl_wr_sel = 4'd4;
    mcycle(); idle();
    ctl_addr_sel = 2'd1;
    #1;
    n_total++; if (bus.mem_addr !== 16'hFFFF) $display("FAIL dec16_wrap: got %h want ffff", bus.mem_addr); else n_pass++;
    ctl_reg_op = 3'd3; ctl_wr_sel = 4'd5;
    mcycle(); idle();
    ctl_addr_sel = 2'd1;
    #1;
    n_total++; if (bus.mem_addr !== 16'hFFFF) $display("FAIL inc16_odd: got %h want ffff", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_high_index();
    load_reg(4'd12, 8'h55);
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd12; ctl_rd2_sel = 4'd0;
    #1;
    n_total++; if (bus.mem_addr !== 16'h0001) $display("FAIL idx12_read: got %h want 0001", bus.mem_addr); else n_pass++;
    ctl_addr_sel = 2'd3;
    #1;
    n_total++; if (bus.mem_addr !== 16'hFF01) $display("FAIL addr_ff_rd2: got %h want ff01", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_pc_load();
    load_reg(4'd10, 8'h12); load_reg(4'd11, 8'h34);
    ctl_addr_sel = 2'd3; ctl_rd2_sel = 4'd11;
    #1;
    n_total++; if (bus.mem_addr !== 16'hFF34) $display("FAIL addr_ff_z: got %h want ff34", bus.mem_addr); else n_pass++;
    idle();
    ctl_pc_op = 2'd2; ctl_ir_load = 1'b1; bus.mem_data_in = 8'hA5;
    mcycle(); idle();
    n_total++; if (bus.mem_addr !== 16'h1234) $display("FAIL pc_load: got %h want 1234", bus.mem_addr); else n_pass++;
    n_total++; if (ir !== 8'hA5) $display("FAIL ir_load: got %h want a5", ir); else n_pass++;
    load_reg(4'd10, 8'hFF); load_reg(4'd11, 8'hFF);
    ctl_pc_op = 2'd2;
    mcycle(); idle();
    n_total++; if (bus.mem_addr !== 16'hFFFF) $display("FAIL pc_load_ffff: got %h want ffff", bus.mem_addr); else n_pass++;
    ctl_pc_op = 2'd1;
    mcycle(); idle();
    n_total++; if (bus.mem_addr !== 16'h0000) $display("FAIL pc_wrap: got %h want 0000", bus.mem_addr); else n_pass++;
  endtask

  task automatic test_bus_ctl();
    ctl_mem_en = 1'b1; ctl_mem_wr = 1'b1;
    #1;
    n_total++; if ({bus.mem_enable, bus.mem_write} !== 2'b11) $display("FAIL bus_wr: got %b want 11", {bus.mem_enable, bus.mem_write}); else n_pass++;
    ctl_mem_en = 1'b0;
    #1;
    n_total++; if ({bus.mem_enable, bus.mem_write} !== 2'b00) $display("FAIL bus_idle_wr: got %b want 00", {bus.mem_enable, bus.mem_write}); else n_pass++;
    idle();
  endtask

  task automatic test_stall();
    ctl_pc_op = 2'd1; ctl_mem_en = 1'b1; bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef CPU_DATAPATH_WAIT_STATE_EN
    for (int i = 0; i < 3; i++) begin
      n_total++; if (t_cycle !== 4'd3) $display("FAIL stall_t: got %0d want 3", t_cycle); else n_pass++;
      n_total++; if (m_end !== 1'b0) $display("FAIL stall_m_end: got %b want 0", m_end); else n_pass++;
      n_total++; if (bus.mem_addr !== 16'h0000) $display("FAIL stall_pc: got %h want 0000", bus.mem_addr); else n_pass++;
      @(posedge clk);
      #1;
    end
    n_total++; if (t_cycle !== 4'd3) $display("FAIL stall_t_end: got %0d want 3", t_cycle); else n_pass++;
    bus.mem_ready = 1'b1;
    #1;
`endif
    n_total++; if (m_end !== 1'b1) $display("FAIL ready_m_end: got %b want 1", m_end); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (t_cycle !== 4'd0) $display("FAIL ready_t: got %0d want 0", t_cycle); else n_pass++;
    n_total++; if (bus.mem_addr !== 16'h0001) $display("FAIL ready_pc: got %h want 0001", bus.mem_addr); else n_pass++;
    idle();
  endtask

  task automatic test_reset_in_stall();
    idle();
    reset2 = 1'b0;
    ctl_reg_op = 3'd2; ctl_wr_sel = 4'd0; bus2.mem_data_in = 8'h77; ctl_pc_op = 2'd1;
    repeat (2) @(posedge clk);
    #1 idle();
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd0; ctl_rd2_sel = 4'd1;
    #1;
    n_total++; if (bus2.mem_addr !== 16'h7700) $display("FAIL t2_load_b: got %h want 7700", bus2.mem_addr); else n_pass++;
    ctl_addr_sel = 2'd0;
    #1;
    n_total++; if (bus2.mem_addr !== 16'h0101) $display("FAIL t2_pc: got %h want 0101", bus2.mem_addr); else n_pass++;
    ctl_pc_op = 2'd1; ctl_mem_en = 1'b1; bus2.mem_ready = 1'b0;
    @(posedge clk);
    #1;
`ifdef CPU_DATAPATH_WAIT_STATE_EN
    n_total++; if (m_end2 !== 1'b0) $display("FAIL t2_stall_m_end: got %b want 0", m_end2); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (t_cycle2 !== 4'd1) $display("FAIL t2_stall_t: got %0d want 1", t_cycle2); else n_pass++;
`else
    n_total++; if (m_end2 !== 1'b1) $display("FAIL t2_ready_ignored: got %b want 1", m_end2); else n_pass++;
`endif
    reset2 = 1'b1;
    #1;
    n_total++; if (m_end2 !== 1'b0) $display("FAIL t2_m_end_reset: got %b want 0", m_end2); else n_pass++;
    @(posedge clk);
    #1 reset2 = 1'b0;
    idle();
    n_total++; if (t_cycle2 !== 4'd0) $display("FAIL t2_reset_t: got %0d want 0", t_cycle2); else n_pass++;
    n_total++; if (bus2.mem_addr !== 16'h0100) $display("FAIL t2_reset_pc: got %h want 0100", bus2.mem_addr); else n_pass++;
    ctl_addr_sel = 2'd2; ctl_rd1_sel = 4'd0; ctl_rd2_sel = 4'd1;
    #1;
    n_total++; if (bus2.mem_addr !== 16'h0000) $display("FAIL t2_reset_regs: got %h want 0000", bus2.mem_addr); else n_pass++;
    idle();
  endtask

  initial begin
    test_reset();
    test_pc_inc();
    test_add();
    test_sub_inc();
    test_flags_logic();
    test_inc16();
    test_high_index();
    test_pc_load();
    test_bus_ctl();
    test_stall();
    test_reset_in_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
